// File: rtl/matmul_seq_pkg.sv
// Shared types and MMIO word addresses for the matrix-multiply sequencer.
package matmul_seq_pkg;

  typedef enum logic [3:0] {
    StPollRd,
    StPollChk,
    StCfgRd,
    StCfgWt,
    StARd,
    StAWt,
    StBRd,
    StBWt,
    StCWr,
    StClr,
    StDone
  } matmul_seq_state_t;

  localparam int unsigned MMIO_MATMUL_A_IN  = 32'h000;
  localparam int unsigned MMIO_MATMUL_B_IN  = 32'h100;
  localparam int unsigned MMIO_MATMUL_C_OUT = 32'h200;
  localparam int unsigned MMIO_MATMUL_DIM_M = 32'h600;
  localparam int unsigned MMIO_MATMUL_DIM_N = 32'h700;
  localparam int unsigned MMIO_MATMUL_DIM_P = 32'h800;
  localparam int unsigned MMIO_MATMUL_FLAG  = 32'hA00;

  localparam logic [2:0] CfgLastIdx = 3'd5;

  // Configuration registers are fetched in this fixed order.
  function automatic int unsigned cfg_addr(input logic [2:0] idx);
    int unsigned addr;
    unique case (idx)
      3'd0:    addr = MMIO_MATMUL_A_IN;
      3'd1:    addr = MMIO_MATMUL_B_IN;
      3'd2:    addr = MMIO_MATMUL_C_OUT;
      3'd3:    addr = MMIO_MATMUL_DIM_M;
      3'd4:    addr = MMIO_MATMUL_DIM_N;
      default: addr = MMIO_MATMUL_DIM_P;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Loop counters and running A/B/C word pointers for the i/j/k matmul walk.
module matmul_addr_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_i,
  input  logic                  step_k_i,
  input  logic                  step_elem_i,
  input  logic [ADDR_WIDTH-1:0] a_base_i,
  input  logic [ADDR_WIDTH-1:0] b_base_i,
  input  logic [ADDR_WIDTH-1:0] c_base_i,
  input  logic [DATA_WIDTH-1:0] dim_m_i,
  input  logic [DATA_WIDTH-1:0] dim_n_i,
  input  logic [DATA_WIDTH-1:0] dim_p_i,
  output logic [ADDR_WIDTH-1:0] a_ptr_o,
  output logic [ADDR_WIDTH-1:0] b_ptr_o,
  output logic [ADDR_WIDTH-1:0] c_ptr_o,
  output logic                  last_k_o,
  output logic                  last_elem_o
);

  logic [DATA_WIDTH-1:0] i_q, j_q, k_q;
  logic [ADDR_WIDTH-1:0] a_row_q, a_ptr_q, b_col_q, b_ptr_q, c_ptr_q;
  logic [ADDR_WIDTH-1:0] n_step, p_step;

  assign n_step = ADDR_WIDTH'(dim_n_i);
  assign p_step = ADDR_WIDTH'(dim_p_i);

  assign a_ptr_o     = a_ptr_q;
  assign b_ptr_o     = b_ptr_q;
  assign c_ptr_o     = c_ptr_q;
  assign last_k_o    = (k_q == dim_n_i - DATA_WIDTH'(1));
  assign last_elem_o = (i_q == dim_m_i - DATA_WIDTH'(1)) && (j_q == dim_p_i - DATA_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_row_q <= '0;
      a_ptr_q <= '0;
      b_col_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
    end else if (init_i) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_row_q <= a_base_i;
      a_ptr_q <= a_base_i;
      b_col_q <= b_base_i;
      b_ptr_q <= b_base_i;
      c_ptr_q <= c_base_i;
    end else if (step_elem_i) begin
      k_q     <= '0;
      c_ptr_q <= c_ptr_q + ADDR_WIDTH'(1);
      if (j_q == dim_p_i - DATA_WIDTH'(1)) begin
        // Column wrap: move A to the next row, B back to column 0.
        j_q     <= '0;
        i_q     <= i_q + DATA_WIDTH'(1);
        a_row_q <= a_row_q + n_step;
        a_ptr_q <= a_row_q + n_step;
        b_col_q <= b_base_i;
        b_ptr_q <= b_base_i;
      end else begin
        j_q     <= j_q + DATA_WIDTH'(1);
        a_ptr_q <= a_row_q;
        b_col_q <= b_col_q + ADDR_WIDTH'(1);
        b_ptr_q <= b_col_q + ADDR_WIDTH'(1);
      end
    end else if (step_k_i) begin
      k_q     <= k_q + DATA_WIDTH'(1);
      a_ptr_q <= a_ptr_q + ADDR_WIDTH'(1);
      b_ptr_q <= b_ptr_q + p_step;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Polls the matmul MMIO flag, fetches config, computes C = A*B with one MAC and
// writes C back through a shared, grant-arbitrated memory port.
module matmul_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] FlagAddr = ADDR_WIDTH'(MMIO_MATMUL_FLAG);

  matmul_seq_state_t state_q;
  logic [2:0]            cfg_idx_q;
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [DATA_WIDTH-1:0] dim_m_q, dim_n_q, dim_p_q;
  logic [DATA_WIDTH-1:0] a_q, acc_q, mac_sum;
  logic                  last_k_q, last_elem_q;
  logic                  mem_req_q, mem_we_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  ag_init, ag_step_k, ag_step_elem, ag_last_k, ag_last_elem;
  logic [ADDR_WIDTH-1:0] a_ptr, b_ptr, c_ptr;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Product and sum both wrap at DATA_WIDTH, so the low bits are sign-agnostic.
  assign mac_sum = acc_q + a_q * mem_rdata;

  // k advances when B is granted so the next A address is ready one edge later.
  assign ag_init      = (state_q == StCfgWt) && (cfg_idx_q == CfgLastIdx);
  assign ag_step_k    = (state_q == StBRd) && mem_gnt && !ag_last_k;
  assign ag_step_elem = (state_q == StBWt) && last_k_q;

  matmul_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i      (clk),
    .rst_i      (rst),
    .init_i     (ag_init),
    .step_k_i   (ag_step_k),
    .step_elem_i(ag_step_elem),
    .a_base_i   (a_base_q),
    .b_base_i   (b_base_q),
    .c_base_i   (c_base_q),
    .dim_m_i    (dim_m_q),
    .dim_n_i    (dim_n_q),
    .dim_p_i    (dim_p_q),
    .a_ptr_o    (a_ptr),
    .b_ptr_o    (b_ptr),
    .c_ptr_o    (c_ptr),
    .last_k_o   (ag_last_k),
    .last_elem_o(ag_last_elem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPollRd;
      cfg_idx_q   <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      dim_m_q     <= '0;
      dim_n_q     <= '0;
      dim_p_q     <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      last_k_q    <= 1'b0;
      last_elem_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StPollRd: begin
          // Coming out of reset the request is not yet raised; raise it first.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= FlagAddr;
          end else if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StPollChk;
          end
        end
        StPollChk: begin
          mem_req_q <= 1'b1;
          mem_we_q  <= 1'b0;
          if (mem_rdata != '0) begin
            busy_q     <= 1'b1;
            cfg_idx_q  <= '0;
            mem_addr_q <= ADDR_WIDTH'(cfg_addr(3'd0));
            state_q    <= StCfgRd;
          end else begin
            mem_addr_q <= FlagAddr;
            state_q    <= StPollRd;
          end
        end
        StCfgRd: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StCfgWt;
          end
        end
        StCfgWt: begin
          unique case (cfg_idx_q)
            3'd0:    a_base_q <= ADDR_WIDTH'(mem_rdata);
            3'd1:    b_base_q <= ADDR_WIDTH'(mem_rdata);
            3'd2:    c_base_q <= ADDR_WIDTH'(mem_rdata);
            3'd3:    dim_m_q  <= mem_rdata;
            3'd4:    dim_n_q  <= mem_rdata;
            default: dim_p_q  <= mem_rdata;
          endcase
          mem_req_q <= 1'b1;
          if (cfg_idx_q != CfgLastIdx) begin
            cfg_idx_q  <= cfg_idx_q + 3'd1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ADDR_WIDTH'(cfg_addr(cfg_idx_q + 3'd1));
            state_q    <= StCfgRd;
          end else if (dim_m_q == '0 || dim_n_q == '0 || mem_rdata == '0) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= FlagAddr;
            mem_wdata_q <= '0;
            state_q     <= StClr;
          end else begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= a_base_q;
            state_q    <= StARd;
          end
        end
        StARd: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StAWt;
          end
        end
        StAWt: begin
          a_q        <= mem_rdata;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= b_ptr;
          state_q    <= StBRd;
        end
        StBRd: begin
          if (mem_gnt) begin
            last_k_q  <= ag_last_k;
            mem_req_q <= 1'b0;
            state_q   <= StBWt;
          end
        end
        StBWt: begin
          mem_req_q <= 1'b1;
          if (last_k_q) begin
            acc_q       <= '0;
            last_elem_q <= ag_last_elem;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= c_ptr;
            mem_wdata_q <= mac_sum;
            state_q     <= StCWr;
          end else begin
            acc_q      <= mac_sum;
            mem_we_q   <= 1'b0;
            mem_addr_q <= a_ptr;
            state_q    <= StARd;
          end
        end
        StCWr: begin
          if (mem_gnt) begin
            if (last_elem_q) begin
              mem_addr_q  <= FlagAddr;
              mem_wdata_q <= '0;
              state_q     <= StClr;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= a_ptr;
              state_q    <= StARd;
            end
          end
        end
        StClr: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          busy_q     <= 1'b0;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= FlagAddr;
          state_q    <= StPollRd;
        end
        default: state_q <= StPollRd;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: memory model, expected-write queue, timing checks.
module tb_matmul_sequencer;

  localparam logic [31:0] FLAG_ADDR = 32'hA00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_gnt, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] a_vals [16];
  logic [31:0] b_vals [16];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0, clr_cyc = -1, done_cyc = -1, wr_count = 0;
  bit t0_valid = 0, done_seen = 0, idle_chk = 0, rand_gnt = 0;
  bit held_prev = 0, p_req = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  matmul_sequencer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_gnt  (mem_gnt),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory behind the arbiter: read data one cycle after a granted read.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rdata <= rd(mem_addr);
    end
  end

  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst) begin
      if (held_prev)
        check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_we, p_addr, p_wdata});
      if (idle_chk) begin
        check("idle_busy", busy, 1'b0);
        check("idle_alternate", mem_req, !p_req);
        if (mem_req) check("idle_addr", {mem_we, mem_addr}, {1'b0, FLAG_ADDR});
      end
      if (mem_req && mem_gnt) begin
        if (!mem_we && mem_addr == FLAG_ADDR && rd(FLAG_ADDR) != 0 && !t0_valid) begin
          t0 = cyc;
          t0_valid = 1;
        end
        if (mem_we) begin
          wr_count++;
          check("wr_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
          end
          if (mem_addr == FLAG_ADDR) clr_cyc = cyc - t0;
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc = cyc - t0;
        check("busy_at_done", busy, 1'b1);
      end
    end
    held_prev = mem_req && !mem_gnt && !rst;
    p_req   = mem_req;
    p_we    = mem_we;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
  end

  task automatic push_expected(input int m, input int n, input int p, input logic [31:0] cb);
    logic [31:0] acc;
    wr_t w;
    if (m * n * p != 0) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < p; j++) begin
          acc = '0;
          for (int k = 0; k < n; k++) acc = acc + a_vals[i*n+k] * b_vals[k*p+j];
          w.addr = cb + 32'(i * p + j);
          w.data = acc;
          exp_q.push_back(w);
        end
      end
    end
    w.addr = FLAG_ADDR;
    w.data = '0;
    exp_q.push_back(w);
  endtask

  task automatic start_job(input int m, input int n, input int p,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb);
    t0_valid = 0;
    done_seen = 0;
    clr_cyc = -1;
    done_cyc = -1;
    for (int i = 0; i < m * n; i++) mem[ab + 32'(i)] = a_vals[i];
    for (int i = 0; i < n * p; i++) mem[bb + 32'(i)] = b_vals[i];
    mem[32'h000] = ab;
    mem[32'h100] = bb;
    mem[32'h200] = cb;
    mem[32'h600] = 32'(m);
    mem[32'h700] = 32'(n);
    mem[32'h800] = 32'(p);
    push_expected(m, n, p, cb);
    @(posedge clk);
    #1;
    mem[FLAG_ADDR] = 32'h1;
  endtask

  task automatic finish_job(input int m, input int n, input int p, input bit chk_time);
    int exp_clr;
    for (int c = 0; c < 5000 && !done_seen; c++) @(negedge clk);
    check("done_seen", done_seen, 1'b1);
    check("queue_empty", exp_q.size(), 0);
    check("flag_cleared", rd(FLAG_ADDR), 0);
    exp_clr = (m * n * p == 0) ? 14 : 14 + m * p * (4 * n + 1);
    if (chk_time) begin
      check("clr_cycle", clr_cyc, exp_clr);
      check("done_cycle", done_cyc, exp_clr + 1);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {mem_req, mem_we, busy, done, mem_addr, mem_wdata}, '0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check("req_after_reset", mem_req, 1'b1);

    // Idle polling with flag clear
    idle_chk = 1;
    repeat (20) @(negedge clk);
    idle_chk = 0;

    // 2x2x2
    a_vals[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vals[0:3] = '{32'd5, 32'd6, 32'd7, 32'd8};
    start_job(2, 2, 2, 32'h1000, 32'h1010, 32'h1020);
    finish_job(2, 2, 2, 1);
    check("c00", rd(32'h1020), 32'd19);
    check("c01", rd(32'h1021), 32'd22);
    check("c10", rd(32'h1022), 32'd43);
    check("c11", rd(32'h1023), 32'd50);

    // Signed and wrapping MAC
    a_vals[0] = -32'sd3;
    b_vals[0] = 32'd7;
    start_job(1, 1, 1, 32'h2000, 32'h2010, 32'h2020);
    finish_job(1, 1, 1, 1);
    check("c_signed", rd(32'h2020), 32'hFFFF_FFEB);
    a_vals[0] = 32'h7FFF_FFFF;
    b_vals[0] = 32'd2;
    start_job(1, 1, 1, 32'h3000, 32'h3010, 32'h3020);
    finish_job(1, 1, 1, 1);
    check("c_wrap", rd(32'h3020), 32'hFFFF_FFFE);

    // Zero dimension: only the flag clear
    start_job(3, 0, 2, 32'h3800, 32'h3810, 32'h3820);
    finish_job(3, 0, 2, 1);

    // 2x3x2 under random grant
    a_vals[0:5] = '{32'd3, -32'sd2, 32'd5, 32'd7, 32'd1, -32'sd4};
    b_vals[0:5] = '{32'd2, 32'd9, -32'sd6, 32'd4, 32'd8, -32'sd1};
    rand_gnt = 1;
    start_job(2, 3, 2, 32'h4000, 32'h4010, 32'h4020);
    finish_job(2, 3, 2, 0);
    rand_gnt = 0;
    repeat (3) @(negedge clk);

    // Reset during the third C element, then full rerun
    a_vals[0:3] = '{32'd2, -32'sd1, 32'd6, 32'd3};
    b_vals[0:3] = '{32'd4, 32'd5, -32'sd7, 32'd1};
    base = wr_count;
    start_job(2, 2, 2, 32'h5000, 32'h5010, 32'h5020);
    for (int c = 0; c < 500 && wr_count < base + 2; c++) @(negedge clk);
    check("writes_before_reset", wr_count - base, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset_outputs");
    check("flag_kept", rd(FLAG_ADDR), 32'h1);
    exp_q.delete();
    push_expected(2, 2, 2, 32'h5020);
    t0_valid = 0;
    done_seen = 0;
    rst = 1'b0;
    finish_job(2, 2, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
